cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Complete stage between the functional units and the physical register file.
- Buffers finished results from NUM_FU functional units in per-unit FIFOs and picks one per cycle by round-robin.
- The picked result drives a registered common data bus (CDB), which feeds the PRF write port (write_en/write_tag/write_data) and reservation-station/map-table wakeup.
- Supports backpressure to the FUs and a full squash on branch mispredict.

Parameters:
- NUM_FU, 4, number of functional-unit result sources
- FIFO_DEPTH, 2, entries per FU result FIFO (power of two, >=2)
- PHYS_REG_SZ, 64, number of physical registers
- XLEN, 32, data width
- PREG_W, $clog2(PHYS_REG_SZ), physical tag width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  mispredict flush; synchronous
- fu_valid  in  NUM_FU  result valid per FU
- fu_tag  in  NUM_FU x PREG_W  destination physical register per FU
- fu_data  in  NUM_FU x XLEN  result value per FU
- fu_ready  out  NUM_FU  FU may present a result this cycle
- cdb_valid  out  1  broadcast valid (PRF write_en)
- cdb_tag  out  PREG_W  broadcast tag (PRF write_tag)
- cdb_data  out  XLEN  broadcast value (PRF write_data)
- cdb_src  out  $clog2(NUM_FU)  index of the FU whose result is on the CDB

Behaviour:
- Reset:
  - All FIFOs are emptied.
  - cdb_valid, cdb_tag, cdb_data and cdb_src are 0.
  - The round-robin pointer rr is 0.
  - fu_ready is 0 while reset is high.
- fu_ready[i]:
  - Equals (count[i] < FIFO_DEPTH) && !reset && !squash.
  - Depends only on the registered occupancy, never on this cycle's grant.
- Enqueue:
  - Occurs when fu_valid[i] && fu_ready[i]; the entry is written at the clock edge.
  - Enqueue while fu_ready[i]=0 is dropped. The FU must hold its result; the bench flags this as a protocol error.
- Tag 0 (hardwired-zero register):
  - Accepted (handshake completes) but not stored.
  - Never appears on the CDB.
- Arbitration (combinational, registered output):
  - Each cycle, scan FIFOs i = rr, rr+1, ... mod NUM_FU and grant the first non-empty one.
  - The granted head is dequeued.
  - At the edge, cdb_* is loaded with its tag/data/source and cdb_valid=1. If there is no grant, cdb_valid=0; tag/data/src hold their last value.
  - On a grant to index g, rr becomes (g+1) mod NUM_FU. With no grant, rr is unchanged.
- Latency and throughput:
  - A result presented in cycle t is stored at the end of t, arbitrated in t+1, and visible on the CDB in t+2.
  - There is no FIFO bypass.
  - Sustained throughput is 1 result/cycle total.
  - A single always-valid FU with other FUs idle gets 1/cycle.
- Enqueue and dequeue of the same FIFO in one cycle are both performed; count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Squash:
  - At the edge where squash=1, all FIFOs are emptied and cdb_valid becomes 0.
  - FU inputs in that cycle are ignored.
  - rr is unchanged.
  - The CDB entry already visible in the squash cycle is still valid in that cycle. Downstream ignores or accepts it per its own squash rule.
- Reset has priority over squash. Squash has priority over enqueue/grant.
- Reset asserted mid-operation discards all buffered results with no CDB broadcast.
- No duplicate broadcasts: each stored result appears on the CDB exactly once unless it is flushed.

Test Plan:
- Latency:
  - Stimulus: after reset, FU0 presents tag=5 data=0xDEAD in cycle 1 only.
  - Required: cdb_valid=1, tag=5, data=0xDEAD, src=0 in cycle 3 only; fu_ready stays 1.
- Round-robin:
  - Stimulus: all 4 FUs present one result (tags 1,2,3,4) in the same cycle, rr=0.
  - Required: CDB tags 1,2,3,4 on consecutive cycles, src 0,1,2,3; rr returns to 0.
- Backpressure:
  - Stimulus: FU0 and FU1 each present one result every cycle.
  - Required: the CDB alternates src 0/1 with no bubble.
  - Required: each fu_ready stays 1, or drops to 0 when its FIFO reaches FIFO_DEPTH=2; no result is lost or duplicated (scoreboard).
- Tag 0:
  - Stimulus: FU2 presents tag=0, then tag=9.
  - Required: only tag 9 appears on the CDB, 2 cycles after it was presented.
- Squash:
  - Stimulus: fill FU0 and FU3 FIFOs, then assert squash for one cycle while FU1 presents tag=7.
  - Required: the cycle after squash, cdb_valid=0; no buffered result or tag 7 ever appears; fu_ready=0 during squash, 1 after.
- Reset mid-operation:
  - Stimulus: with 3 entries buffered, assert reset for 1 cycle.
  - Required: all outputs 0 the next cycle, fu_ready=0 during reset, rr=0; a subsequent FU3 result is broadcast with src=3 at 2-cycle latency.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: completion stage between the functional units and the PRF.
// Each FU owns a small result FIFO; one non-empty FIFO is picked per cycle by
// round-robin and its head is broadcast on a registered common data bus that
// drives the PRF write port and the wakeup network. A squash flushes every
// buffered result; results to physical register 0 are accepted and discarded.
module cdb_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int PHYS_REG_SZ = 64,
  parameter int XLEN        = 32,
  parameter int PREG_W      = $clog2(PHYS_REG_SZ)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU-1:0][PREG_W-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]      fu_data,
  output logic [NUM_FU-1:0]                fu_ready,
  output logic                             cdb_valid,
  output logic [PREG_W-1:0]                cdb_tag,
  output logic [XLEN-1:0]                  cdb_data,
  output logic [$clog2(NUM_FU)-1:0]        cdb_src
);

  localparam int SRC_W = $clog2(NUM_FU);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PREG_W-1:0] ZERO_TAG = {PREG_W{1'b0}};

  // FIFO payload storage (no reset needed: validity is tracked by count_q)
  logic [PREG_W-1:0] tag_mem_q  [NUM_FU][FIFO_DEPTH];
  logic [XLEN-1:0]   data_mem_q [NUM_FU][FIFO_DEPTH];

  // FIFO bookkeeping
  logic [NUM_FU-1:0][PTR_W-1:0] wptr_q, wptr_d;
  logic [NUM_FU-1:0][PTR_W-1:0] rptr_q, rptr_d;
  logic [NUM_FU-1:0][CNT_W-1:0] count_q, count_d;

  // Round-robin pointer and registered CDB
  logic [SRC_W-1:0]  rr_q, rr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [PREG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]   cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  // Combinational handshake / arbitration signals
  logic [NUM_FU-1:0] fu_ready_s;
  logic [NUM_FU-1:0] store_s;
  logic [NUM_FU-1:0] deq_s;
  logic              grant_valid_s;
  logic [SRC_W-1:0]  grant_idx_s;
  logic [PREG_W-1:0] head_tag_s;
  logic [XLEN-1:0]   head_data_s;

  // Ready is taken from registered occupancy only; tag-0 results complete the handshake but are not stored
  always_comb begin
    fu_ready_s = {NUM_FU{1'b0}};
    store_s    = {NUM_FU{1'b0}};
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready_s[i] = (count_q[i] < DEPTH_C) && !reset && !squash;
      store_s[i]    = fu_valid[i] && fu_ready_s[i] && (fu_tag[i] != ZERO_TAG);
    end
  end

  // Round-robin scan starting at rr_q: first non-empty FIFO wins
  always_comb begin
    logic [SRC_W-1:0] idx_s;
    grant_valid_s = 1'b0;
    grant_idx_s   = {SRC_W{1'b0}};
    idx_s         = {SRC_W{1'b0}};
    for (int k = 0; k < NUM_FU; k++) begin
      idx_s = SRC_W'((int'(rr_q) + k) % NUM_FU);
      if (!grant_valid_s && (count_q[idx_s] != CNT_ZERO)) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = idx_s;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Decode the grant into per-FIFO dequeue strobes and select the granted head entry
  always_comb begin
    deq_s = {NUM_FU{1'b0}};
    for (int i = 0; i < NUM_FU; i++) begin
      deq_s[i] = grant_valid_s && (grant_idx_s == SRC_W'(i));
    end
    head_tag_s  = tag_mem_q[grant_idx_s][rptr_q[grant_idx_s]];
    head_data_s = data_mem_q[grant_idx_s][rptr_q[grant_idx_s]];
  end

  // Next-state: squash empties every FIFO and kills the broadcast; otherwise enqueue, dequeue and load the CDB
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rr_d        = rr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (squash) begin
      wptr_d      = {(NUM_FU*PTR_W){1'b0}};
      rptr_d      = {(NUM_FU*PTR_W){1'b0}};
      count_d     = {(NUM_FU*CNT_W){1'b0}};
      cdb_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (store_s[i]) begin
          wptr_d[i] = wptr_q[i] + PTR_ONE;
        end else begin
          wptr_d[i] = wptr_q[i];
        end
        if (deq_s[i]) begin
          rptr_d[i] = rptr_q[i] + PTR_ONE;
        end else begin
          rptr_d[i] = rptr_q[i];
        end
        case ({store_s[i], deq_s[i]})
          2'b10:   count_d[i] = count_q[i] + CNT_ONE;
          2'b01:   count_d[i] = count_q[i] - CNT_ONE;
          default: count_d[i] = count_q[i];
        endcase
      end
      if (grant_valid_s) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = head_tag_s;
        cdb_data_d  = head_data_s;
        cdb_src_d   = grant_idx_s;
        rr_d        = SRC_W'((int'(grant_idx_s) + 32'sd1) % NUM_FU);
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; reset outranks squash
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q      <= {(NUM_FU*PTR_W){1'b0}};
      rptr_q      <= {(NUM_FU*PTR_W){1'b0}};
      count_q     <= {(NUM_FU*CNT_W){1'b0}};
      rr_q        <= {SRC_W{1'b0}};
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= ZERO_TAG;
      cdb_data_q  <= {XLEN{1'b0}};
      cdb_src_q   <= {SRC_W{1'b0}};
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  // Payload write: store_s is already gated off by reset and squash through fu_ready
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (store_s[i]) begin
        tag_mem_q[i][wptr_q[i]]  <= fu_tag[i];
        data_mem_q[i][wptr_q[i]] <= fu_data[i];
      end
    end
  end

  assign fu_ready  = fu_ready_s;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule
